// File: rtl/data_sync_scheduler.sv
// rtl/data_sync_scheduler.sv - round-robin scheduler sharing one data synchronizer channel
module data_sync_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 5,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic [BUS_WIDTH-1:0]         Unsync_bus,
    output logic                         bus_enable,
    output logic                         busy
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int SUM_W   = PTR_W + 1;
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     own;
    logic [PTR_W-1:0]     own_d;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_d;
    logic [BUS_WIDTH-1:0] bus_d;
    logic                 enable_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [NUM_REQ-1:0]   done_d;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [SUM_W-1:0]     scan;

    // Round-robin search: first requesting index starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + SUM_W'(k);
            if (scan >= NUM_REQ_S) begin
                scan = scan - NUM_REQ_S;
            end
            if (!win_found && req[scan[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[PTR_W-1:0];
            end
        end
    end

    // Next-state and next-output logic; the bus word only moves on the IDLE->HOLD edge
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        own_d    = own;
        cnt_d    = cnt;
        bus_d    = Unsync_bus;
        enable_d = bus_enable;
        grant_d  = '0;
        done_d   = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    bus_d            = data_in[int'(win_idx)*BUS_WIDTH +: BUS_WIDTH];
                    enable_d         = 1'b1;
                    grant_d[win_idx] = 1'b1;
                    own_d            = win_idx;
                    ptr_d            = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    cnt_d            = HOLD_LOAD;
                    state_d          = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    enable_d    = 1'b0;
                    done_d[own] = 1'b1;
                    cnt_d       = GAP_LOAD;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without issuing done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            own        <= '0;
            cnt        <= '0;
            Unsync_bus <= '0;
            bus_enable <= 1'b0;
            grant      <= '0;
            done       <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            own        <= own_d;
            cnt        <= cnt_d;
            Unsync_bus <= bus_d;
            bus_enable <= enable_d;
            grant      <= grant_d;
            done       <= done_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_sync_scheduler.sv
// tb/tb_data_sync_scheduler.sv - scoreboard bench for data_sync_scheduler
module tb_data_sync_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int BUS_WIDTH   = 8;
    localparam int HOLD_CYCLES = 5;
    localparam int GAP_CYCLES  = 3;
    localparam int PERIOD      = HOLD_CYCLES + GAP_CYCLES + 1;

    typedef struct {
        int                   idx;
        logic [BUS_WIDTH-1:0] word;
        int                   period;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [BUS_WIDTH-1:0]         Unsync_bus;
    logic                         bus_enable;
    logic                         busy;

    exp_t                 exp_q[$];
    int                   n_vec;
    int                   n_err;
    int                   cyc;
    int                   grant_cyc;
    int                   prev_cyc;
    int                   en_cnt;
    int                   low_cnt;
    int                   owner;
    logic                 pending;
    logic                 stable_ok;
    logic [BUS_WIDTH-1:0] cur_word;

    data_sync_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .BUS_WIDTH  (BUS_WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .done      (done),
        .Unsync_bus(Unsync_bus),
        .bus_enable(bus_enable),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_vec = n_vec + 1;
        if (act !== req_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [BUS_WIDTH-1:0] w);
        data_in[i*BUS_WIDTH +: BUS_WIDTH] = w;
    endtask

    task automatic push(input int i, input logic [BUS_WIDTH-1:0] w, input int period);
        exp_t e;
        e.idx    = i;
        e.word   = w;
        e.period = period;
        exp_q.push_back(e);
    endtask

    // Advance until a grant appears; optionally drop the granted request as the contract asks
    task automatic wait_grant(input bit drop);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            tick();
            if (grant != '0) begin
                seen = 1'b1;
                if (drop) req = req & ~grant;
            end
        end
        check("grant_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bus"}, 32'(Unsync_bus), 32'd0);
        check({tag, "_enable"}, 32'(bus_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every grant and checks window timing on every done
    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
            prev_cyc = -1000;
            low_cnt = 0;
        end else begin
            if (grant != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("grant", 32'(grant), 32'(onehot(e.idx)));
                    check("bus_word", 32'(Unsync_bus), 32'(e.word));
                    check("enable_at_grant", 32'(bus_enable), 32'd1);
                    if (e.period != 0) begin
                        check("period", 32'(cyc - prev_cyc), 32'(e.period));
                        check("gap_low", 32'(low_cnt), 32'(GAP_CYCLES + 1));
                    end
                    cur_word  = e.word;
                    owner     = e.idx;
                    grant_cyc = cyc;
                    prev_cyc  = cyc;
                    en_cnt    = 0;
                    stable_ok = 1'b1;
                    pending   = 1'b1;
                end
            end
            if (done != '0) begin
                if (!pending) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    check("done", 32'(done), 32'(onehot(owner)));
                    check("hold_len", 32'(cyc - grant_cyc), 32'(HOLD_CYCLES));
                    check("enable_len", 32'(en_cnt), 32'(HOLD_CYCLES));
                    check("enable_off_at_done", 32'(bus_enable), 32'd0);
                    check("bus_stable", 32'(stable_ok), 32'd1);
                    pending = 1'b0;
                end
                low_cnt = 0;
            end
            if (bus_enable) begin
                en_cnt = en_cnt + 1;
                if (Unsync_bus !== cur_word) stable_ok = 1'b0;
            end else begin
                low_cnt = low_cnt + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        grant_cyc = 0;
        prev_cyc  = -1000;
        en_cnt    = 0;
        low_cnt   = 0;
        owner     = 0;
        pending   = 1'b0;
        stable_ok = 1'b1;
        cur_word  = '0;
        rst       = 1'b1;
        req       = '0;
        data_in   = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Single request, data scrambled every cycle after grant
        set_word(2, 8'hA5);
        push(2, 8'hA5, 0);
        req = 4'b0100;
        wait_grant(1'b1);
        check("s1_busy_c0", 32'(busy), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            data_in = $urandom;
            tick();
        end
        check("s1_busy_c7", 32'(busy), 32'd1);
        tick();
        check("s1_busy_c8", 32'(busy), 32'd0);
        check("s1_enable_c8", 32'(bus_enable), 32'd0);
        check("s1_bus_kept", 32'(Unsync_bus), 32'hA5);

        // All four requesting continuously after reset
        rst = 1'b1;
        tick();
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        data_in = 32'h44332211;
        push(0, 8'h11, 0);
        push(1, 8'h22, PERIOD);
        push(2, 8'h33, PERIOD);
        push(3, 8'h44, PERIOD);
        push(0, 8'h11, PERIOD);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_grant(1'b0);
        req = '0;
        repeat (10) tick();

        // Contention with rotated pointer (ptr is now 1)
        set_word(1, 8'h21);
        push(1, 8'h21, 0);
        req = 4'b0010;
        wait_grant(1'b1);
        repeat (5) tick();
        check("s3_in_gap", 32'(busy), 32'd1);
        data_in = 32'h93929190;
        push(3, 8'h93, PERIOD);
        push(0, 8'h90, PERIOD);
        push(1, 8'h91, PERIOD);
        req = 4'b1011;
        for (int i = 0; i < 3; i++) wait_grant(1'b1);
        repeat (10) tick();

        // Reset in HOLD cycle 2: asynchronous abort, no done
        set_word(0, 8'h5A);
        push(0, 8'h5A, 0);
        req = 4'b0001;
        wait_grant(1'b1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        set_word(0, 8'h3C);
        push(0, 8'h3C, 0);
        req = 4'b0001;
        wait_grant(1'b1);
        repeat (10) tick();
        check("s4_idle", 32'(busy), 32'd0);

        // Request withdrawn while another transfer is in GAP
        set_word(2, 8'h77);
        push(2, 8'h77, 0);
        req = 4'b0100;
        wait_grant(1'b1);
        repeat (5) tick();
        req = 4'b0010;
        tick();
        req = '0;
        repeat (10) tick();
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_enable", 32'(bus_enable), 32'd0);
        check("s5_bus_kept", 32'(Unsync_bus), 32'h77);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("no_pending", 32'(pending), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_sync_scheduler.md
# data_sync_scheduler

Source-domain scheduler that shares one multi-bit data synchronizer channel between NUM_REQ requesters. It arbitrates round-robin, drives the shared `Unsync_bus`/`bus_enable` pair with a stable word for a fixed hold window, and then enforces a quiet gap. The gap lets the destination-side synchronizer see a clean enable rising edge for every transfer. It sits in the transmitting clock domain, directly in front of the data synchronizer's unsynchronized inputs.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- BUS_WIDTH, 8, data word width
- HOLD_CYCLES, 5, cycles `bus_enable` stays high per transfer (≥1); sized by integrator to cover destination sync stages + capture
- GAP_CYCLES, 3, cycles in GAP state after each transfer (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- data_in  in  NUM_REQ*BUS_WIDTH  requester i word at bits [i*BUS_WIDTH +: BUS_WIDTH]
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: word accepted
- done  out  NUM_REQ  one-hot, 1-cycle pulse: hold window finished
- Unsync_bus  out  BUS_WIDTH  word to synchronizer, registered
- bus_enable  out  1  enable to synchronizer, registered
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, HOLD, GAP. Internal: rr pointer `ptr` (log2 NUM_REQ bits), down-counter `cnt`, current owner index `own`.
- IDLE: if any `req` bit set, winner w = first set bit scanning ptr, ptr+1, …, wrapping modulo NUM_REQ. At the edge:
  - `Unsync_bus` ← data_in slice w; `bus_enable` ← 1; `grant` ← onehot(w)
  - `own` ← w; `ptr` ← (w+1) mod NUM_REQ; `cnt` ← HOLD_CYCLES−1; → HOLD
  - No request: all outputs hold, `grant`/`done` 0.
- HOLD: `grant` ← 0.
  - `cnt`≠0: decrement.
  - `cnt`=0: `bus_enable` ← 0; `done` ← onehot(own); `cnt` ← GAP_CYCLES−1; → GAP.
- GAP: `done` ← 0. `cnt`≠0: decrement; `cnt`=0: → IDLE.
- `Unsync_bus` changes only at the IDLE→HOLD edge. It keeps the last word through GAP and IDLE and never changes while `bus_enable`=1.
- `req` and `data_in` are ignored outside IDLE.
- Requester contract: hold `req` and the data word stable until `grant`. Data is sampled at the grant edge. Drop `req` in the `grant` cycle; if `req` is still high at the next IDLE arbitration, it is a new request.
- A request withdrawn before being granted is simply not served; no error state.
- Reset (any time, including mid-HOLD/GAP): immediate abort, no `done` issued.
  - State IDLE; `ptr`=0, `cnt`=0, `own`=0.
  - `Unsync_bus`=0, `bus_enable`=0, `grant`=0, `done`=0, `busy`=0.

## Timing
- Edge numbering: edge 0 is the IDLE edge that sees a request. A cycle is named by the edge that starts it: cycle k runs from edge k to edge k+1.
- `grant` high in cycle 0 only. `bus_enable` high in cycles 0 … HOLD_CYCLES−1, i.e. for exactly HOLD_CYCLES cycles.
- `done` high in cycle HOLD_CYCLES only; `bus_enable` low from that cycle.
- GAP covers cycles HOLD_CYCLES … HOLD_CYCLES+GAP_CYCLES−1.
- IDLE re-entered in cycle HOLD_CYCLES+GAP_CYCLES. The earliest next grant is at the following edge.
- Transfer period (grant to grant) = HOLD_CYCLES+GAP_CYCLES+1. `bus_enable` low for GAP_CYCLES+1 cycles between transfers.
- Defaults: period 9; `bus_enable` 5 high / 4 low.
- `busy` is high from cycle 0 through the last GAP cycle (HOLD_CYCLES+GAP_CYCLES cycles total).
- All outputs are registered; no combinational path from `req`/`data_in` to any output.

## Test plan
- Single request (defaults): `req`=0100, word 2 = 8'hA5, req dropped on grant.
  - `grant`=0100 for 1 cycle; `Unsync_bus`=A5 with `bus_enable` high 5 cycles.
  - `done`=0100 in cycle 5; `busy` low from cycle 8.
- All four requesting continuously after reset, words 11/22/33/44:
  - Grants in order 0,1,2,3,0,… every 9 cycles.
  - Bus sequence 11,22,33,44; `bus_enable` low ≥4 cycles between words.
- Contention with rotated pointer: serve req 1 alone, then assert `req`=1011 in GAP → next grant is requester 3, then 0, then 1.
- Stability: change `data_in` of granted and non-granted requesters every cycle during HOLD → `Unsync_bus` constant until the next grant edge.
- Reset mid-HOLD (cycle 2): all outputs 0 asynchronously, no `done`. After release, `req`=0001 → grant 0 with a full 5-cycle window.
- Withdrawn request: `req`=0010 raised then dropped while another transfer is in GAP → no grant to requester 1; scheduler stays IDLE with `bus_enable`=0.
